// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the external 8-bit combinational ALU: accepts one command,
// issues registered operands, then writes the result back to a 4x8 register file and a flag register.
module alu_op_sequencer #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic       cmd_imm_en,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_res,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_of,
  input  logic       alu_cf,
  output logic       done_valid,
  output logic       done_err,
  output logic [7:0] done_res,
  output logic [3:0] flags,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LAST_ALU = 4'b1010;
  localparam logic [3:0] OP_LOADI    = 4'b1111;

  state_t     r_state;
  logic [7:0] r_regs [NREG];
  logic [3:0] r_op;
  logic [1:0] r_rd;
  logic [7:0] r_imm;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [3:0] r_alu_op;
  logic       r_done_valid;
  logic       r_done_err;
  logic [7:0] r_done_res;
  logic [3:0] r_flags;

  logic       w_is_alu;
  logic       w_is_loadi;

  assign w_is_alu   = (r_op <= OP_LAST_ALU);
  assign w_is_loadi = (r_op == OP_LOADI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      // NOTE: the register file is cleared by reset because software relies on R0-R3 reading 0 after reset.
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_op         <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
      r_done_res   <= '0;
      r_flags      <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so every read sees pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op     <= cmd_op;
            r_rd     <= cmd_rd;
            r_imm    <= cmd_imm;
            r_alu_a  <= r_regs[cmd_rs1];
            r_alu_b  <= cmd_imm_en ? cmd_imm : r_regs[cmd_rs2];
            r_alu_op <= cmd_op;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_done_valid <= 1'b1;
          r_state      <= S_DONE;
          if (w_is_alu) begin
            r_regs[r_rd] <= alu_res;
            r_flags      <= {alu_zf, alu_sf, alu_of, alu_cf};
            r_done_res   <= alu_res;
            r_done_err   <= 1'b0;
          end else if (w_is_loadi) begin
            r_regs[r_rd] <= r_imm;
            r_done_res   <= r_imm;
            r_done_err   <= 1'b0;
          end else begin
            r_done_err   <= 1'b1;
          end
        end
        S_DONE: begin
          r_done_valid <= 1'b0;
          r_done_err   <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign done_valid = r_done_valid;
  assign done_err   = r_done_err;
  assign done_res   = r_done_res;
  assign flags      = r_flags;
  assign dbg_data   = r_regs[dbg_addr];

endmodule
